// File: rtl/pitch_shift_sched.sv
// pitch_shift_sched: sequences one FFT frame through the PitchShift bin
// remapping datapath.
//   - Applies a pending (clamped) semitone setting at the frame boundary.
//   - Zero-clears the destination buffer (N writes).
//   - Streams source bins 0..N-1 into PitchShift and scatters each result
//     into the destination buffer at PitchShift's output index.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 frame request (accepted in IDLE only)
//   semitones_in/_wr      requested signed shift and its latch strobe
//   busy, done            frame in progress / one-cycle completion pulse
//   src_rd_*              source buffer read port (data 1 cycle after en)
//   ps_*                  PitchShift interface (sole driver of shift_wr_en)
//   dst_wr_*              destination buffer write port
module pitch_shift_sched #(
  parameter int N      = 2048,
  parameter int IDX_W  = 11,
  parameter int DATA_W = 44,
  parameter int PS_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4:0]        semitones_in,
  input  logic              semitones_wr,
  output logic              busy,
  output logic              done,
  output logic              src_rd_en,
  output logic [IDX_W-1:0]  src_rd_addr,
  input  logic [DATA_W-1:0] src_rd_data,
  output logic [DATA_W-1:0] ps_data_in,
  output logic [IDX_W-1:0]  ps_input_index,
  output logic [4:0]        ps_shift_semitones,
  output logic              ps_shift_wr_en,
  input  logic [DATA_W-1:0] ps_data_out,
  input  logic [IDX_W-1:0]  ps_output_index,
  output logic              dst_wr_en,
  output logic [IDX_W-1:0]  dst_wr_addr,
  output logic [DATA_W-1:0] dst_wr_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_CLEAR, S_SCATTER, S_DRAIN, S_DONE
  } state_t;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);
  localparam logic signed [4:0] SEM_MAX  = 5'sd12;
  localparam logic signed [4:0] SEM_MIN  = -5'sd12;
  localparam int unsigned       LAT      = PS_LAT;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        act_q;        // shift currently applied in PitchShift
  logic [4:0]        pend_q;
  logic              pend_vld_q;
  logic [IDX_W-1:0]  rd_idx_q;     // read address delayed to match src_rd_data
  logic [DATA_W-1:0] din_hold_q;   // keeps ps_data_in stable outside SCATTER/DRAIN
  // Valid tag per pipeline stage: [0] = data at PitchShift input,
  // [LAT] = result at PitchShift output.
  logic [LAT:0]      vld_q, vld_d;
  logic              upstream_vld;
  logic signed [4:0] sem_s;
  logic [4:0]        sem_clamped;

  assign sem_s       = semitones_in;
  assign sem_clamped = (sem_s > SEM_MAX) ? SEM_MAX :
                       (sem_s < SEM_MIN) ? SEM_MIN : sem_s;

  // DRAIN exits on the cycle the last result is written, i.e. once only the
  // output stage may still hold a valid tag.
  always_comb begin
    upstream_vld = 1'b0;
    for (int unsigned i = 0; i < LAT; i++) begin
      upstream_vld = upstream_vld | vld_q[i];
    end
  end

  always_comb begin
    vld_d[0] = (state_q == S_SCATTER);
    for (int unsigned i = 1; i <= LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) state_d = S_CFG;
      end
      S_CFG:  state_d = S_CLEAR;
      S_CLEAR: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == LAST_IDX) state_d = S_SCATTER;
      end
      S_SCATTER: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == LAST_IDX) state_d = S_DRAIN;
      end
      S_DRAIN: if (!upstream_vld) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      act_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      rd_idx_q   <= '0;
      din_hold_q <= '0;
      vld_q      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      // A write in the CFG cycle itself must survive the flag clear so it
      // applies to the following frame.
      if (semitones_wr) begin
        pend_q     <= sem_clamped;
        pend_vld_q <= 1'b1;
      end else if (state_q == S_CFG) begin
        pend_vld_q <= 1'b0;
      end
      if (state_q == S_CFG && pend_vld_q) act_q <= pend_q;
      if (state_q == S_SCATTER) rd_idx_q <= cnt_q;
      if (vld_q[0]) din_hold_q <= src_rd_data;
    end
  end

  assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done           = (state_q == S_DONE);
  assign src_rd_en      = (state_q == S_SCATTER);
  assign src_rd_addr    = src_rd_en ? cnt_q : '0;
  assign ps_data_in     = vld_q[0] ? src_rd_data : din_hold_q;
  assign ps_input_index = rd_idx_q;
  // The pending value is presented combinationally in CFG so the update
  // lands in the same cycle as the write strobe.
  assign ps_shift_wr_en     = (state_q == S_CFG) && pend_vld_q;
  assign ps_shift_semitones = ps_shift_wr_en ? pend_q : act_q;

  assign dst_wr_en   = (state_q == S_CLEAR) || vld_q[LAT];
  assign dst_wr_addr = vld_q[LAT] ? ps_output_index :
                       ((state_q == S_CLEAR) ? cnt_q : '0);
  assign dst_wr_data = vld_q[LAT] ? ps_data_out : '0;

endmodule

// File: tb/tb_pitch_shift_sched.sv
// tb_pitch_shift_sched: three schedulers (PS_LAT = 0, 1, 3, N = 16) share
// stimulus; each has its own source-read model, PitchShift model and
// destination-buffer recorder. Expected frames come from a whole-frame model.
module tb_pitch_shift_sched;
  localparam int N  = 16;
  localparam int IW = 4;
  localparam int DW = 44;
  localparam logic [DW-1:0] XK = 44'h5A5A5A50F0F;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sem_wr = 1'b0;
  logic [4:0] sem_in = '0;
  logic clr = 1'b0;
  int cyc = 0;
  int base = 0;
  int checks = 0;
  int errors = 0;

  logic [DW-1:0] src_mem [N];
  logic [IW-1:0] map [N];
  logic [DW-1:0] exp_mem [N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int L = (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    logic busy, done, src_rd_en, ps_shift_wr_en, dst_wr_en;
    logic [IW-1:0] src_rd_addr, ps_input_index, ps_output_index, dst_wr_addr;
    logic [DW-1:0] src_rd_data = '0;
    logic [DW-1:0] ps_data_in, ps_data_out, dst_wr_data;
    logic [4:0] ps_shift_semitones;
    logic any_out;
    logic [DW-1:0] dst_mem [N];
    int wr_cnt = 0, rd_cnt = 0, rd_bad = 0, clr_bad = 0;
    int done_cnt = 0, done_rel = 0, last_wr_rel = 0, pulse_cnt = 0, pulse_rel = 0;
    logic [4:0] pulse_val = '0;

    pitch_shift_sched #(.N(N), .IDX_W(IW), .DATA_W(DW), .PS_LAT(L)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .semitones_in(sem_in), .semitones_wr(sem_wr),
      .busy(busy), .done(done),
      .src_rd_en(src_rd_en), .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
      .ps_data_in(ps_data_in), .ps_input_index(ps_input_index),
      .ps_shift_semitones(ps_shift_semitones), .ps_shift_wr_en(ps_shift_wr_en),
      .ps_data_out(ps_data_out), .ps_output_index(ps_output_index),
      .dst_wr_en(dst_wr_en), .dst_wr_addr(dst_wr_addr), .dst_wr_data(dst_wr_data)
    );

    assign any_out = busy | done | src_rd_en | (|src_rd_addr) | (|ps_data_in) |
                     (|ps_input_index) | (|ps_shift_semitones) | ps_shift_wr_en |
                     dst_wr_en | (|dst_wr_addr) | (|dst_wr_data);

    always @(posedge clk) if (src_rd_en) src_rd_data <= src_mem[src_rd_addr];

    // PitchShift model: index via map table, data XORed with a key.
    if (L == 0) begin : g_comb
      assign ps_data_out     = ps_data_in ^ XK;
      assign ps_output_index = map[ps_input_index];
    end else begin : g_pipe
      logic [DW-1:0] pd [L];
      logic [IW-1:0] pi [L];
      always @(posedge clk) begin
        pd[0] <= ps_data_in ^ XK;
        pi[0] <= map[ps_input_index];
        for (int s = 1; s < L; s++) begin
          pd[s] <= pd[s-1];
          pi[s] <= pi[s-1];
        end
      end
      assign ps_data_out     = pd[L-1];
      assign ps_output_index = pi[L-1];
    end

    always @(negedge clk) begin
      int rel;
      rel = cyc - base;
      if (clr) begin
        wr_cnt = 0; rd_cnt = 0; rd_bad = 0; clr_bad = 0;
        done_cnt = 0; done_rel = 0; last_wr_rel = 0; pulse_cnt = 0; pulse_rel = 0;
        for (int a = 0; a < N; a++) dst_mem[a] = 44'hBADBADBADBA;
      end
      if (dst_wr_en) begin
        wr_cnt++;
        last_wr_rel = rel;
        dst_mem[dst_wr_addr] = dst_wr_data;
        if (rel >= 2 && rel <= N + 1) begin
          if (int'(dst_wr_addr) != rel - 2 || dst_wr_data != '0) clr_bad++;
        end else if (rel < 2 || rel < N + 3 + L) begin
          clr_bad++;
        end
      end
      if (src_rd_en) begin
        rd_cnt++;
        if (int'(src_rd_addr) != rel - (N + 2)) rd_bad++;
      end
      if (done) begin
        done_cnt++;
        done_rel = rel;
      end
      if (ps_shift_wr_en) begin
        pulse_cnt++;
        pulse_rel = rel;
        pulse_val = ps_shift_semitones;
      end
    end
  end

  function automatic logic [4:0] clamp5(input logic [4:0] p);
    int v;
    v = int'($signed(p));
    if (v > 12) v = 12;
    if (v < -12) v = -12;
    return 5'(v);
  endfunction

  // Whole-frame reference: cleared buffer, then ascending scatter.
  function automatic void build_expected();
    for (int a = 0; a < N; a++) exp_mem[a] = '0;
    for (int i = 0; i < N; i++) exp_mem[map[i]] = src_mem[i] ^ XK;
  endfunction

  function automatic void randomize_frame();
    for (int i = 0; i < N; i++) begin
      src_mem[i] = {12'($urandom), 32'($urandom)};
      map[i]     = IW'($urandom_range(0, N - 1));
    end
  endfunction

  task automatic write_sem(input logic [4:0] v);
    @(posedge clk); #1;
    sem_wr = 1'b1; sem_in = v;
    @(posedge clk); #1;
    sem_wr = 1'b0;
  endtask

  // Returns at cycle 1 (CFG) of the frame.
  task automatic start_frame(input bit w, input logic [4:0] v);
    @(posedge clk); #1;
    start = 1'b1; clr = 1'b1; base = cyc;
    if (w) begin sem_wr = 1'b1; sem_in = v; end
    @(posedge clk); #1;
    start = 1'b0; clr = 1'b0; sem_wr = 1'b0;
  endtask

  task automatic to_rel(input int r);
    while (cyc - base < r) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(output bit timeout);
    timeout = 1'b1;
    for (int t = 0; t < 4 * N + 20; t++) begin
      @(negedge clk);
      if (g_dut[0].done_cnt > 0 && g_dut[1].done_cnt > 0 && g_dut[2].done_cnt > 0) begin
        timeout = 1'b0;
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (g_dut[0].any_out !== 1'b0) begin errors++; $display("FAIL reset_out0 got %b want 0", g_dut[0].any_out); end
    checks++; if (g_dut[1].any_out !== 1'b0) begin errors++; $display("FAIL reset_out1 got %b want 0", g_dut[1].any_out); end
    checks++; if (g_dut[2].any_out !== 1'b0) begin errors++; $display("FAIL reset_out2 got %b want 0", g_dut[2].any_out); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_frame();
    bit to;
    for (int i = 0; i < N; i++) begin
      src_mem[i] = DW'(i + 100);
      map[i]     = IW'(i / 2);
    end
    build_expected();
    start_frame(1'b0, '0);
    wait_done(to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got timeout want done"); end
    checks++; if (g_dut[1].pulse_cnt != 0) begin errors++; $display("FAIL basic_no_pulse got %0d want 0", g_dut[1].pulse_cnt); end
    checks++; if (g_dut[1].clr_bad != 0) begin errors++; $display("FAIL basic_clear_seq got %0d bad want 0", g_dut[1].clr_bad); end
    checks++; if (g_dut[1].rd_cnt != N || g_dut[1].rd_bad != 0) begin errors++; $display("FAIL basic_reads got %0d/%0d bad want %0d/0", g_dut[1].rd_cnt, g_dut[1].rd_bad, N); end
    checks++; if (g_dut[1].done_rel != 2 * N + 4 || g_dut[1].done_cnt != 1) begin errors++; $display("FAIL basic_done_l1 got %0d x%0d want %0d x1", g_dut[1].done_rel, g_dut[1].done_cnt, 2 * N + 4); end
    checks++; if (g_dut[0].done_rel != 2 * N + 3) begin errors++; $display("FAIL basic_done_l0 got %0d want %0d", g_dut[0].done_rel, 2 * N + 3); end
    checks++; if (g_dut[2].done_rel != 2 * N + 6) begin errors++; $display("FAIL basic_done_l3 got %0d want %0d", g_dut[2].done_rel, 2 * N + 6); end
    checks++; if (g_dut[1].last_wr_rel != 2 * N + 3) begin errors++; $display("FAIL basic_last_wr got %0d want %0d", g_dut[1].last_wr_rel, 2 * N + 3); end
    checks++; if (g_dut[0].wr_cnt != 2 * N || g_dut[1].wr_cnt != 2 * N || g_dut[2].wr_cnt != 2 * N) begin errors++; $display("FAIL basic_wr_cnt got %0d/%0d/%0d want %0d", g_dut[0].wr_cnt, g_dut[1].wr_cnt, g_dut[2].wr_cnt, 2 * N); end
    checks++; if (g_dut[0].clr_bad != 0 || g_dut[2].clr_bad != 0) begin errors++; $display("FAIL basic_order_l0l3 got %0d/%0d want 0/0", g_dut[0].clr_bad, g_dut[2].clr_bad); end
    for (int a = 0; a < N; a++) begin
      checks++; if (g_dut[0].dst_mem[a] !== exp_mem[a]) begin errors++; $display("FAIL basic_dst_l0[%0d] got %h want %h", a, g_dut[0].dst_mem[a], exp_mem[a]); end
      checks++; if (g_dut[1].dst_mem[a] !== exp_mem[a]) begin errors++; $display("FAIL basic_dst_l1[%0d] got %h want %h", a, g_dut[1].dst_mem[a], exp_mem[a]); end
      checks++; if (g_dut[2].dst_mem[a] !== exp_mem[a]) begin errors++; $display("FAIL basic_dst_l3[%0d] got %h want %h", a, g_dut[2].dst_mem[a], exp_mem[a]); end
    end
  endtask

  task automatic test_semitone_apply();
    bit to;
    write_sem(5'd6);
    start_frame(1'b0, '0);
    wait_done(to);
    checks++; if (to) begin errors++; $display("FAIL sem6_timeout got timeout want done"); end
    checks++; if (g_dut[1].pulse_cnt != 1 || g_dut[1].pulse_rel != 1) begin errors++; $display("FAIL sem6_pulse got %0d at %0d want 1 at 1", g_dut[1].pulse_cnt, g_dut[1].pulse_rel); end
    checks++; if (g_dut[1].pulse_val !== 5'd6) begin errors++; $display("FAIL sem6_val got %0d want 6", g_dut[1].pulse_val); end
    start_frame(1'b0, '0);
    wait_done(to);
    checks++; if (g_dut[1].pulse_cnt != 0) begin errors++; $display("FAIL sem6_repeat_pulse got %0d want 0", g_dut[1].pulse_cnt); end
    checks++; if (g_dut[1].ps_shift_semitones !== 5'd6) begin errors++; $display("FAIL sem6_hold got %0d want 6", g_dut[1].ps_shift_semitones); end
  endtask

  task automatic test_clamp();
    bit to;
    write_sem(5'(-16));
    write_sem(5'd15);
    start_frame(1'b0, '0);
    wait_done(to);
    checks++; if (g_dut[1].pulse_cnt != 1 || g_dut[1].pulse_val !== 5'd12) begin errors++; $display("FAIL clamp_hi got %0d x%0d want 12 x1", g_dut[1].pulse_val, g_dut[1].pulse_cnt); end
    write_sem(5'b10000);
    start_frame(1'b0, '0);
    wait_done(to);
    checks++; if (g_dut[1].pulse_cnt != 1 || g_dut[1].pulse_val !== 5'b10100) begin errors++; $display("FAIL clamp_lo got %b x%0d want 10100 x1", g_dut[1].pulse_val, g_dut[1].pulse_cnt); end
  endtask

  task automatic test_same_cycle_and_cfg_write();
    bit to;
    start_frame(1'b1, 5'd3);
    wait_done(to);
    checks++; if (g_dut[1].pulse_cnt != 1 || g_dut[1].pulse_val !== 5'd3) begin errors++; $display("FAIL same_cycle got %0d x%0d want 3 x1", g_dut[1].pulse_val, g_dut[1].pulse_cnt); end
    start_frame(1'b0, '0);
    sem_wr = 1'b1; sem_in = 5'd7;   // sampled at the end of the CFG cycle
    @(posedge clk); #1;
    sem_wr = 1'b0;
    wait_done(to);
    checks++; if (g_dut[1].pulse_cnt != 0) begin errors++; $display("FAIL cfg_write_now got %0d pulses want 0", g_dut[1].pulse_cnt); end
    start_frame(1'b0, '0);
    wait_done(to);
    checks++; if (g_dut[1].pulse_cnt != 1 || g_dut[1].pulse_val !== 5'd7) begin errors++; $display("FAIL cfg_write_next got %0d x%0d want 7 x1", g_dut[1].pulse_val, g_dut[1].pulse_cnt); end
  endtask

  task automatic test_midframe_write();
    bit to;
    randomize_frame();
    build_expected();
    start_frame(1'b0, '0);
    to_rel(20);
    sem_wr = 1'b1; sem_in = 5'(-6);
    @(posedge clk); #1;
    sem_wr = 1'b0;
    repeat (3) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
    end
    wait_done(to);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (to) begin errors++; $display("FAIL mid_timeout got timeout want done"); end
    checks++; if (g_dut[1].pulse_cnt != 0) begin errors++; $display("FAIL mid_no_pulse got %0d want 0", g_dut[1].pulse_cnt); end
    checks++; if (g_dut[1].done_cnt != 1 || g_dut[1].busy !== 1'b0) begin errors++; $display("FAIL mid_one_done got %0d busy %b want 1 busy 0", g_dut[1].done_cnt, g_dut[1].busy); end
    for (int a = 0; a < N; a++) begin
      checks++; if (g_dut[1].dst_mem[a] !== exp_mem[a]) begin errors++; $display("FAIL mid_dst[%0d] got %h want %h", a, g_dut[1].dst_mem[a], exp_mem[a]); end
    end
    start_frame(1'b0, '0);
    wait_done(to);
    checks++; if (g_dut[1].pulse_cnt != 1 || g_dut[1].pulse_val !== 5'b11010) begin errors++; $display("FAIL mid_next_pulse got %b x%0d want 11010 x1", g_dut[1].pulse_val, g_dut[1].pulse_cnt); end
  endtask

  task automatic test_reset_midframe();
    bit to;
    start_frame(1'b0, '0);
    to_rel(15);
    sem_wr = 1'b1; sem_in = 5'd9;
    @(posedge clk); #1;
    sem_wr = 1'b0;
    to_rel(20);
    rst_n = 1'b0;
    #1;
    checks++; if (g_dut[0].any_out !== 1'b0 || g_dut[1].any_out !== 1'b0 || g_dut[2].any_out !== 1'b0) begin
      errors++; $display("FAIL rst_mid_out got %b%b%b want 000", g_dut[0].any_out, g_dut[1].any_out, g_dut[2].any_out); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checks++; if (g_dut[1].done_cnt != 0) begin errors++; $display("FAIL rst_mid_no_done got %0d want 0", g_dut[1].done_cnt); end
    randomize_frame();
    build_expected();
    start_frame(1'b0, '0);
    wait_done(to);
    checks++; if (to || g_dut[1].done_rel != 2 * N + 4) begin errors++; $display("FAIL rst_after_done got %0d to %b want %0d", g_dut[1].done_rel, to, 2 * N + 4); end
    checks++; if (g_dut[1].pulse_cnt != 0 || g_dut[1].ps_shift_semitones !== 5'd0) begin errors++; $display("FAIL rst_after_shift got %0d x%0d want 0 x0", g_dut[1].ps_shift_semitones, g_dut[1].pulse_cnt); end
    for (int a = 0; a < N; a++) begin
      checks++; if (g_dut[1].dst_mem[a] !== exp_mem[a]) begin errors++; $display("FAIL rst_after_dst[%0d] got %h want %h", a, g_dut[1].dst_mem[a], exp_mem[a]); end
    end
  endtask

  task automatic test_random_frames();
    bit to;
    bit w;
    logic [4:0] v;
    for (int f = 0; f < 4; f++) begin
      randomize_frame();
      build_expected();
      w = 1'($urandom);
      v = 5'($urandom);
      if (w) write_sem(v);
      start_frame(1'b0, '0);
      wait_done(to);
      checks++; if (to || g_dut[0].done_rel != 2 * N + 3 || g_dut[2].done_rel != 2 * N + 6) begin
        errors++; $display("FAIL rnd_done f%0d got %0d/%0d want %0d/%0d", f, g_dut[0].done_rel, g_dut[2].done_rel, 2 * N + 3, 2 * N + 6); end
      checks++; if (g_dut[1].pulse_cnt != int'(w) || (w && g_dut[1].pulse_val !== clamp5(v))) begin
        errors++; $display("FAIL rnd_sem f%0d got %0d x%0d want %0d x%0d", f, g_dut[1].pulse_val, g_dut[1].pulse_cnt, clamp5(v), int'(w)); end
      for (int a = 0; a < N; a++) begin
        checks++; if (g_dut[0].dst_mem[a] !== exp_mem[a]) begin errors++; $display("FAIL rnd_dst_l0 f%0d[%0d] got %h want %h", f, a, g_dut[0].dst_mem[a], exp_mem[a]); end
        checks++; if (g_dut[1].dst_mem[a] !== exp_mem[a]) begin errors++; $display("FAIL rnd_dst_l1 f%0d[%0d] got %h want %h", f, a, g_dut[1].dst_mem[a], exp_mem[a]); end
        checks++; if (g_dut[2].dst_mem[a] !== exp_mem[a]) begin errors++; $display("FAIL rnd_dst_l3 f%0d[%0d] got %h want %h", f, a, g_dut[2].dst_mem[a], exp_mem[a]); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      src_mem[i] = '0;
      map[i]     = '0;
    end
    test_reset();
    test_basic_frame();
    test_semitone_apply();
    test_clamp();
    test_same_cycle_and_cfg_write();
    test_midframe_write();
    test_reset_midframe();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pitch_shift_sched.md
Name: pitch_shift_sched

Overview:
- Frame scheduler that sequences one FFT frame through the PitchShift bin-remapping datapath.
- On each frame request it applies any pending semitone setting at the frame boundary and zero-clears the destination spectrum buffer.
- It then streams every source bin (index 0..N-1) from the source buffer into PitchShift and scatters each result into the destination buffer at the remapped index.
- Sits between the FFT frame buffers and PitchShift. It is the only block that drives PitchShift's shift_wr_en.

Parameters:
- N, 2048, bins per frame (power of 2).
- IDX_W, 11, log2(N).
- DATA_W, 44, complex bin width.
- PS_LAT, 1, PitchShift latency in cycles from data_in/input_index to data_out/output_index (0 = combinational).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  frame request; accepted only in IDLE.
- semitones_in  in  5  signed requested shift.
- semitones_wr  in  1  latch semitones_in as pending.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at frame completion.
- src_rd_en  out  1  source buffer read strobe.
- src_rd_addr  out  IDX_W  source bin address.
- src_rd_data  in  DATA_W  source bin data, valid 1 cycle after src_rd_en.
- ps_data_in  out  DATA_W  to PitchShift data_in.
- ps_input_index  out  IDX_W  to PitchShift input_index.
- ps_shift_semitones  out  5  to PitchShift shift_semitones.
- ps_shift_wr_en  out  1  to PitchShift shift_wr_en.
- ps_data_out  in  DATA_W  from PitchShift data_out.
- ps_output_index  in  IDX_W  from PitchShift output_index.
- dst_wr_en  out  1  destination buffer write strobe.
- dst_wr_addr  out  IDX_W  destination address.
- dst_wr_data  out  DATA_W  destination data.

Behaviour:
- Reset values:
  - All outputs 0.
  - active shift = 0; pending flag = 0; state = IDLE.
  - Valid pipeline cleared.
- Reset asserted mid-frame aborts immediately. No done pulse. The partially written destination buffer is undefined.
- Semitone handling:
  - semitones_wr latches semitones_in into the pending register and sets the pending flag, in any state.
  - Value is clamped to -12..+12 (e.g. -16 -> -12, 15 -> +12).
  - A later write before the frame boundary overwrites the earlier one.
- States: IDLE -> CFG -> CLEAR -> SCATTER -> DRAIN -> DONE -> IDLE.
- IDLE:
  - busy = 0.
  - start = 1 moves to CFG; busy = 1 from the next cycle.
  - start is ignored in any other state.
- CFG (1 cycle):
  - If pending, ps_shift_semitones <= pending value and ps_shift_wr_en = 1 for this cycle only; pending flag is cleared.
  - Otherwise ps_shift_wr_en stays 0 and ps_shift_semitones holds.
  - semitones_wr and start in the same IDLE cycle: the new value applies to this frame.
  - semitones_wr in the CFG cycle itself: remains pending for the next frame.
- CLEAR (N cycles):
  - dst_wr_en = 1, dst_wr_data = 0, dst_wr_addr = 0..N-1 incrementing.
- SCATTER (N cycles):
  - src_rd_en = 1, src_rd_addr = 0..N-1.
  - One cycle later: ps_data_in = src_rd_data and ps_input_index = the delayed address, with a valid tag.
  - PS_LAT cycles after that: dst_wr_en = tag, dst_wr_addr = ps_output_index, dst_wr_data = ps_data_out.
  - ps_output_index is written unmodified. Collisions are last-write-wins (highest source index wins).
- DRAIN: hold until the valid pipeline (1 + PS_LAT stages) empties.
- DONE (1 cycle): done = 1, busy = 0, then IDLE.
- Latency requirements:
  - Start accepted at edge 0 gives: CFG cycle 1, CLEAR cycles 2..N+1, reads N+2..2N+1.
  - Last destination write at cycle 2N+2+PS_LAT; done at cycle 2N+3+PS_LAT.
  - Exactly 2N destination writes per frame.
- Address counters wrap from N-1 to 0 with no overflow flag. The next state is entered on the wrap cycle.
- ps_input_index and ps_data_in hold their last values outside SCATTER/DRAIN. No src reads occur outside SCATTER.

Test Plan:
- Reset, no config, start (N=16, PS_LAT=1) -> no ps_shift_wr_en; 16 zero writes to addr 0..15; 16 reads; done at cycle 36; 32 writes total.
- semitones_wr=6 in IDLE then start -> ps_shift_wr_en single pulse in CFG, ps_shift_semitones=6; second start with no write -> no pulse, value holds 6.
- semitones_wr=-16 then 15 before start -> applied value +12; with 5'b10000 alone -> applied -12 (5'b10100).
- semitones_wr=-6 during SCATTER -> current frame unchanged; next frame CFG pulses with -6; start pulses while busy -> ignored, exactly one done.
- PitchShift model mapping i -> i/2, src data = i+100 -> dst[k] final = 2k+101 (last write wins) for k<8; dst[8..15]=0; vary PS_LAT=0,3 -> done at 35 and 38.
- rst_n low at cycle 20 of frame -> all outputs 0 immediately, no done; next start runs a full frame normally with shift 0.
